sramlike_bridge_arbiter: RTL and testbench
==========================================

// Module: sramlike_bridge_arbiter
// PURPOSE
//   Shares the single sram-like port of the AXI bridge between two sram-like masters.
//   Master 0 is the icache refill path; master 1 is the data path (dcache or the uncached bypass).
//   Allows one outstanding transaction at a time.
//   Priority is fixed: data first, with an anti-starvation override for inst.
//   Routes addr_ok/data_ok back to the owning master only.
// PARAMETERS
//   STARVE_LIMIT  4  consecutive data grants while inst waits; at the limit the next grant goes to inst
//   CNT_W         3  width of the starvation counter; must satisfy 2**CNT_W > STARVE_LIMIT
// PORTS
//   clk            in   1   single clock, rising edge
//   resetn         in   1   asynchronous, active-low reset
//   m0_req         in   1   inst master request; held with its fields until m0_addr_ok
//   m0_wr          in   1   inst master write
//   m0_size        in   2   inst master size
//   m0_addr        in   32  inst master address
//   m0_wdata       in   32  inst master write data
//   m0_rdata       out  32  bridge rdata, forwarded unconditionally
//   m0_addr_ok     out  1   address accepted for m0
//   m0_data_ok     out  1   data returned for m0
//   m1_*           -    -   data master; same set as m0_*
//   br_req/wr/size/addr/wdata  out  1/1/2/32/32  request to the bridge
//   br_rdata       in   32  bridge read data
//   br_addr_ok     in   1   bridge address handshake
//   br_data_ok     in   1   bridge data handshake
//   proto_err      out  1   sticky: br_data_ok seen while no transaction is outstanding
// BEHAVIOUR
//   FSM state: IDLE, GRANT, WAIT_DATA; owner register (0 = inst, 1 = data).
//   Reset: state IDLE, owner 0, starve counter 0, proto_err 0.
//     All outputs 0 except rdata, which passes through.
//   IDLE
//     If any req is present, latch the owner and go to GRANT. Nothing is forwarded in this cycle.
//     Choose m1 if m1_req, unless m0_req is also set and starve == STARVE_LIMIT; otherwise m0.
//   Starvation counter, updated on the IDLE->GRANT transition:
//     m1 granted while m0_req=1: counter +1, saturating.
//     m0 granted: counter cleared.
//     m1 granted while m0_req=0: counter cleared.
//   GRANT
//     br_* = owner's req/wr/size/addr/wdata, combinational.
//     Owner's addr_ok = br_addr_ok & owner_req. Non-owner addr_ok = 0.
//     br_req & br_addr_ok: go to WAIT_DATA.
//     Owner drops req before acceptance: return to IDLE, no transaction.
//   WAIT_DATA
//     br_req = 0. Owner's data_ok = br_data_ok. Non-owner data_ok = 0.
//     br_data_ok: go to IDLE.
//   Simultaneous addr_ok and data_ok from the bridge in GRANT:
//     Cannot be ours (nothing outstanding). Set proto_err and still take the addr_ok transition.
//   br_data_ok in IDLE: ignored, except proto_err is set.
//   Latency
//     1-cycle arbitration bubble: req seen in cycle N gives the earliest br_req in cycle N+1.
//     Back-to-back throughput is one transaction per (bridge latency + 2) cycles.
//   Ordering: the non-owner is never acknowledged. Its req simply stays pending.
//   Reset mid-transaction returns to IDLE immediately.
//     The bridge shares resetn, so no transaction is left dangling.
// STRUCTURE
//   Shared package (cache_pkg): ARB_IDLE/ARB_GRANT/ARB_WAIT state encodings (2 bits);
//     OWNER_INST=1'b0, OWNER_DATA=1'b1.
//   Flat module. No sub-module is needed; the request mux is a 2:1 select on owner.
// TESTING
//   1. Inst only: m0 read, addr 0xBFC00000; bridge addr_ok at cycle 2, data_ok at cycle 5
//      with 0x3C1D0001.
//      -> m0_addr_ok at cycle 2, m0_data_ok and m0_rdata=0x3C1D0001 at cycle 5;
//         all m1 acks 0 throughout.
//   2. Collision: m0_req and m1_req (write 0x8000_0010, wdata 0xDEADBEEF) both rise in cycle 0.
//      -> br_addr=0x8000_0010 first; the m0 transaction is issued right after the m1 data_ok.
//   3. Starvation: m1_req held high continuously, m0_req high.
//      -> exactly 4 m1 grants, then 1 m0 grant, then the counter restarts.
//   4. Abort: owner m1 drops req in GRANT before br_addr_ok.
//      -> FSM back to IDLE next cycle, br_req=0, no ack to either master.
//   5. Stray br_data_ok pulse in IDLE.
//      -> proto_err=1 and stays 1; no m*_data_ok; a subsequent normal transaction completes.
//   6. resetn asserted in WAIT_DATA.
//      -> all acks and br_req are 0 immediately; after release a fresh m0 request
//         completes normally.

Source files
------------

// File: rtl/sramlike_bridge_arbiter_pkg.sv
// Shared definitions for the sram-like bridge arbiter.
//   arb_state_t  : arbiter FSM state encoding (2 bits)
//   OWNER_INST   : owner code for master 0 (icache refill path)
//   OWNER_DATA   : owner code for master 1 (dcache / uncached bypass)
package sramlike_bridge_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

endpackage

// File: rtl/sramlike_bridge_arbiter_if.sv
// One sram-like port: request fields from the master, handshakes and read
// data back from the slave.
//   master modport : drives req/wr/size/addr/wdata, receives rdata/addr_ok/data_ok
//   slave modport  : the opposite direction
interface sramlike_bridge_arbiter_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok
    );

endinterface

// File: rtl/sramlike_bridge_arbiter.sv
// Shares the single sram-like bridge port between the inst master (m0) and
// the data master (m1). One transaction in flight at a time; data has fixed
// priority, but after STARVE_LIMIT consecutive data grants taken while inst
// was waiting, the next grant goes to inst.
//   clk       : clock, rising edge
//   resetn    : asynchronous active-low reset
//   m0, m1    : master-facing ports (slave modport)
//   br        : bridge-facing port (master modport)
//   proto_err : sticky flag, bridge returned data_ok with nothing outstanding
module sramlike_bridge_arbiter
    import sramlike_bridge_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                              clk,
    input  logic                              resetn,
    sramlike_bridge_arbiter_if.slave          m0,
    sramlike_bridge_arbiter_if.slave          m1,
    sramlike_bridge_arbiter_if.master         br,
    output logic                              proto_err
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] STARVE_SAT = '1;

    arb_state_t       state_reg, state_next;
    logic             owner_reg, owner_next;
    logic [CNT_W-1:0] starve_reg, starve_next;
    logic             proto_err_reg, proto_err_next;

    logic             owner_req;
    logic             owner_wr;
    logic [1:0]       owner_size;
    logic [31:0]      owner_addr;
    logic [31:0]      owner_wdata;
    logic             pick_data;

    // 2:1 request mux on the latched owner
    assign owner_req   = (owner_reg == OWNER_DATA) ? m1.req   : m0.req;
    assign owner_wr    = (owner_reg == OWNER_DATA) ? m1.wr    : m0.wr;
    assign owner_size  = (owner_reg == OWNER_DATA) ? m1.size  : m0.size;
    assign owner_addr  = (owner_reg == OWNER_DATA) ? m1.addr  : m0.addr;
    assign owner_wdata = (owner_reg == OWNER_DATA) ? m1.wdata : m0.wdata;

    // Data wins unless inst is waiting and has already been passed over
    // STARVE_LIMIT times in a row.
    assign pick_data = m1.req && !(m0.req && (starve_reg == STARVE_LIM));

    // Read data is broadcast; only data_ok tells a master it is theirs.
    assign m0.rdata  = br.rdata;
    assign m1.rdata  = br.rdata;
    assign proto_err = proto_err_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= ARB_IDLE;
            owner_reg     <= OWNER_INST;
            starve_reg    <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            starve_reg    <= starve_next;
            proto_err_reg <= proto_err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        starve_next = starve_reg;
        br.req      = 1'b0;
        br.wr       = 1'b0;
        br.size     = 2'b00;
        br.addr     = 32'h0;
        br.wdata    = 32'h0;
        m0.addr_ok  = 1'b0;
        m0.data_ok  = 1'b0;
        m1.addr_ok  = 1'b0;
        m1.data_ok  = 1'b0;

        // Any data_ok outside WAIT cannot belong to us: covers the stray
        // pulse in IDLE and the simultaneous addr_ok/data_ok in GRANT.
        proto_err_next = proto_err_reg | (br.data_ok && (state_reg != ARB_WAIT));

        case (state_reg)
            ARB_IDLE: begin
                if (m0.req || m1.req) begin
                    state_next = ARB_GRANT;
                    if (pick_data) begin
                        owner_next = OWNER_DATA;
                        if (m0.req) begin
                            if (starve_reg != STARVE_SAT) begin
                                starve_next = starve_reg + 1'b1;
                            end
                        end else begin
                            starve_next = '0;
                        end
                    end else begin
                        owner_next  = OWNER_INST;
                        starve_next = '0;
                    end
                end
            end

            ARB_GRANT: begin
                br.req   = owner_req;
                br.wr    = owner_wr;
                br.size  = owner_size;
                br.addr  = owner_addr;
                br.wdata = owner_wdata;
                if (owner_reg == OWNER_DATA) begin
                    m1.addr_ok = br.addr_ok & owner_req;
                end else begin
                    m0.addr_ok = br.addr_ok & owner_req;
                end
                if (owner_req && br.addr_ok) begin
                    state_next = ARB_WAIT;
                end else if (!owner_req) begin
                    // Owner withdrew before acceptance: nothing was issued.
                    state_next = ARB_IDLE;
                end
            end

            ARB_WAIT: begin
                if (owner_reg == OWNER_DATA) begin
                    m1.data_ok = br.data_ok;
                end else begin
                    m0.data_ok = br.data_ok;
                end
                if (br.data_ok) begin
                    state_next = ARB_IDLE;
                end
            end

            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sramlike_bridge_arbiter.sv
// Bench for sramlike_bridge_arbiter: directed master traffic, a bridge
// responder with programmable latencies, a transaction-level reference model
// checked every cycle, and literal expectations for each scenario.
module tb_sramlike_bridge_arbiter;

    localparam int STARVE_LIMIT = 4;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          abort_after;
    } mreq_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic proto_err;

    sramlike_bridge_arbiter_if m0_if ();
    sramlike_bridge_arbiter_if m1_if ();
    sramlike_bridge_arbiter_if br_if ();

    sramlike_bridge_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .m0        (m0_if),
        .m1        (m1_if),
        .br        (br_if),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    // master drivers
    mreq_t mq [2][$];
    mreq_t cur [2];
    bit    active [2];
    bit    ack_seen [2];
    int    held [2];
    int    start_cyc [2];

    // bridge responder
    int          addr_lat = 1;
    int          data_lat = 1;
    logic [31:0] rdata_val = 32'h0;
    bit          stray = 0;
    bit          pend = 0;
    int          acnt = 0;
    int          dcnt = 0;
    bit          prev_a = 0;
    bit          prev_d = 0;

    // reference model (transaction level)
    bit mb_busy = 0;
    bit mb_acc = 0;
    bit mb_owner = 0;
    int mb_starve = 0;
    bit mb_err = 0;
    bit grant_log [$];

    // observations of the DUT
    logic [31:0] issue_log [$];
    int          breq_rise [$];
    int          breq_hi = 0;
    bit          prev_breq = 0;
    int          aok_cnt [2];
    int          dok_cnt [2];
    int          first_aok [2];
    int          first_dok [2];
    int          dok_cyc [2];
    logic [31:0] dok_rdata [2];
    logic [31:0] last_addr [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int i, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int abort_after);
        mreq_t r;
        r.wr = wr;
        r.size = 2'b10;
        r.addr = addr;
        r.wdata = wdata;
        r.abort_after = abort_after;
        mq[i].push_back(r);
    endtask

    task automatic clear_logs();
        grant_log.delete();
        issue_log.delete();
        breq_rise.delete();
        breq_hi = 0;
        for (int i = 0; i < 2; i++) begin
            aok_cnt[i] = 0;
            dok_cnt[i] = 0;
            first_aok[i] = -1;
            first_dok[i] = -1;
            dok_cyc[i] = -1;
            dok_rdata[i] = 32'h0;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while ((mq[0].size() != 0 || mq[1].size() != 0 || active[0] || active[1] || mb_busy)
                   && n < budget);
        if (n >= budget) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: timeout after %0d cycles", name, budget);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Masters: hold req and fields until addr_ok, then load the next entry.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (!resetn) begin
                    active[i] = 0;
                    ack_seen[i] = 0;
                    mq[i].delete();
                end else begin
                    if (active[i]) begin
                        if (ack_seen[i]) active[i] = 0;
                        else if (cur[i].abort_after > 0 && held[i] >= cur[i].abort_after) active[i] = 0;
                        else held[i]++;
                    end
                    ack_seen[i] = 0;
                    if (!active[i] && mq[i].size() > 0) begin
                        cur[i] = mq[i].pop_front();
                        active[i] = 1;
                        held[i] = 1;
                        start_cyc[i] = cyc;
                    end
                end
            end
            m0_if.req = active[0];
            m0_if.wr = cur[0].wr;
            m0_if.size = cur[0].size;
            m0_if.addr = cur[0].addr;
            m0_if.wdata = cur[0].wdata;
            m1_if.req = active[1];
            m1_if.wr = cur[1].wr;
            m1_if.size = cur[1].size;
            m1_if.addr = cur[1].addr;
            m1_if.wdata = cur[1].wdata;
        end
    end

    // Bridge: addr_ok after addr_lat cycles of br_req, data_ok data_lat
    // cycles after acceptance.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!resetn) begin
                pend = 0; acnt = 0; dcnt = 0; prev_a = 0; prev_d = 0;
                br_if.addr_ok = 0;
                br_if.data_ok = 0;
                br_if.rdata = 32'h0;
            end else begin
                bit a, d;
                if (prev_d) pend = 0;
                if (prev_a) begin pend = 1; dcnt = 0; end
                a = 0;
                d = 0;
                if (br_if.req && !pend) begin
                    acnt++;
                    if (acnt >= addr_lat) begin a = 1; acnt = 0; end
                end else begin
                    acnt = 0;
                end
                if (pend) begin
                    dcnt++;
                    if (dcnt >= data_lat) d = 1;
                end
                prev_d = d && pend;
                if (stray) begin d = 1; stray = 0; end
                br_if.addr_ok = a;
                br_if.data_ok = d;
                br_if.rdata = d ? rdata_val : {16'hA5A5, cyc[15:0]};
                prev_a = a && br_if.req;
            end
        end
    end

    // Per-cycle compare against the reference model, then advance the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                mb_busy = 0; mb_acc = 0; mb_owner = 0; mb_starve = 0; mb_err = 0;
                prev_breq = 0;
            end else begin
                bit req0, req1, oreq, issuing, pick1;
                logic [31:0] oaddr, owdata;
                logic [1:0] osize;
                logic owr;
                req0 = m0_if.req;
                req1 = m1_if.req;
                oreq   = mb_owner ? req1 : req0;
                oaddr  = mb_owner ? m1_if.addr : m0_if.addr;
                owdata = mb_owner ? m1_if.wdata : m0_if.wdata;
                osize  = mb_owner ? m1_if.size : m0_if.size;
                owr    = mb_owner ? m1_if.wr : m0_if.wr;
                issuing = mb_busy && !mb_acc;

                chk("br_req", br_if.req, issuing && oreq);
                chk("m0_addr_ok", m0_if.addr_ok, issuing && !mb_owner && req0 && br_if.addr_ok);
                chk("m1_addr_ok", m1_if.addr_ok, issuing && mb_owner && req1 && br_if.addr_ok);
                chk("m0_data_ok", m0_if.data_ok, mb_acc && !mb_owner && br_if.data_ok);
                chk("m1_data_ok", m1_if.data_ok, mb_acc && mb_owner && br_if.data_ok);
                chk("proto_err", proto_err, mb_err);
                chk("m0_rdata", m0_if.rdata, br_if.rdata);
                chk("m1_rdata", m1_if.rdata, br_if.rdata);
                if (issuing && oreq) begin
                    chk("br_addr", br_if.addr, oaddr);
                    chk("br_wdata", br_if.wdata, owdata);
                    chk("br_size", br_if.size, osize);
                    chk("br_wr", br_if.wr, owr);
                end

                // observations
                if (br_if.req) breq_hi++;
                if (br_if.req && !prev_breq) breq_rise.push_back(cyc);
                prev_breq = br_if.req;
                if (br_if.req && br_if.addr_ok) issue_log.push_back(br_if.addr);
                for (int i = 0; i < 2; i++) begin
                    logic aok, dok;
                    aok = (i == 0) ? m0_if.addr_ok : m1_if.addr_ok;
                    dok = (i == 0) ? m0_if.data_ok : m1_if.data_ok;
                    if (aok) begin
                        ack_seen[i] = 1;
                        aok_cnt[i]++;
                        last_addr[i] = br_if.addr;
                        if (first_aok[i] < 0) first_aok[i] = cyc - start_cyc[i];
                    end
                    if (dok) begin
                        dok_cnt[i]++;
                        if (first_dok[i] < 0) begin
                            first_dok[i] = cyc - start_cyc[i];
                            dok_cyc[i] = cyc;
                            dok_rdata[i] = br_if.rdata;
                        end
                        $display("txn m%0d addr %08h rdata %08h cycle %0d", i, last_addr[i], br_if.rdata, cyc);
                    end
                end

                // model advance
                if (br_if.data_ok && !mb_acc) mb_err = 1;
                if (!mb_busy) begin
                    if (req0 || req1) begin
                        pick1 = req1 && !(req0 && mb_starve >= STARVE_LIMIT);
                        mb_owner = pick1;
                        grant_log.push_back(pick1);
                        if (pick1 && req0) mb_starve = (mb_starve < 7) ? mb_starve + 1 : 7;
                        else mb_starve = 0;
                        mb_busy = 1;
                        mb_acc = 0;
                    end
                end else if (!mb_acc) begin
                    if (oreq && br_if.addr_ok) mb_acc = 1;
                    else if (!oreq) mb_busy = 0;
                end else if (br_if.data_ok) begin
                    mb_busy = 0;
                    mb_acc = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp3 [12];
        bit          expg [12];
        int          d0;

        for (int i = 0; i < 2; i++) begin
            cur[i].wr = 0; cur[i].size = 0; cur[i].addr = 0; cur[i].wdata = 0; cur[i].abort_after = 0;
            active[i] = 0; ack_seen[i] = 0; held[i] = 0; start_cyc[i] = 0;
        end
        m0_if.req = 0; m0_if.wr = 0; m0_if.size = 0; m0_if.addr = 0; m0_if.wdata = 0;
        m1_if.req = 0; m1_if.wr = 0; m1_if.size = 0; m1_if.addr = 0; m1_if.wdata = 0;
        br_if.addr_ok = 0; br_if.data_ok = 0; br_if.rdata = 0;
        clear_logs();

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_br_req", br_if.req, 1'b0);
        chk("rst_m0_addr_ok", m0_if.addr_ok, 1'b0);
        chk("rst_m1_data_ok", m1_if.data_ok, 1'b0);
        chk("rst_proto_err", proto_err, 1'b0);
        chk("rst_br_addr", br_if.addr, 32'h0);
        @(posedge clk); #4;
        resetn = 1;
        repeat (2) @(posedge clk);

        // 1. inst only read
        clear_logs();
        addr_lat = 2; data_lat = 3; rdata_val = 32'h3C1D0001;
        push(0, 1'b0, 32'hBFC00000, 32'h0, 0);
        wait_done("t1_done", 40);
        chk("t1_addr_ok_cycle", first_aok[0], 2);
        chk("t1_data_ok_cycle", first_dok[0], 5);
        chk("t1_rdata", dok_rdata[0], 32'h3C1D0001);
        chk("t1_m1_acks", aok_cnt[1] + dok_cnt[1], 0);

        // 2. collision: data master first, inst right after its data_ok
        clear_logs();
        addr_lat = 1; data_lat = 2; rdata_val = 32'h11112222;
        push(0, 1'b0, 32'hBFC00100, 32'h0, 0);
        push(1, 1'b1, 32'h80000010, 32'hDEADBEEF, 0);
        wait_done("t2_done", 60);
        chk("t2_issues", issue_log.size(), 2);
        if (issue_log.size() == 2) begin
            chk("t2_first_addr", issue_log[0], 32'h80000010);
            chk("t2_second_addr", issue_log[1], 32'hBFC00100);
        end
        chk("t2_breq_rises", breq_rise.size(), 2);
        if (breq_rise.size() == 2) chk("t2_m0_issue_cycle", breq_rise[1], dok_cyc[1] + 2);

        // 3. starvation: 4 data grants, then inst, twice
        clear_logs();
        addr_lat = 1; data_lat = 1; rdata_val = 32'h0BADF00D;
        for (int k = 0; k < 10; k++) push(1, 1'b0, 32'h1000 + 32'(4 * k), 32'h0, 0);
        push(0, 1'b0, 32'h2000, 32'h0, 0);
        push(0, 1'b0, 32'h2004, 32'h0, 0);
        exp3 = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h2000, 32'h1010,
                 32'h1014, 32'h1018, 32'h101C, 32'h2004, 32'h1020, 32'h1024};
        expg = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
        wait_done("t3_done", 200);
        chk("t3_issues", issue_log.size(), 12);
        chk("t3_model_grants", grant_log.size(), 12);
        for (int k = 0; k < 12; k++) begin
            if (k < issue_log.size()) chk($sformatf("t3_addr%0d", k), issue_log[k], exp3[k]);
            if (k < grant_log.size()) chk($sformatf("t3_model_grant%0d", k), grant_log[k], expg[k]);
        end

        // 4. abort: data master withdraws before acceptance
        clear_logs();
        addr_lat = 4; data_lat = 1;
        push(1, 1'b0, 32'h00000040, 32'h0, 2);
        wait_done("t4_done", 40);
        chk("t4_breq_cycles", breq_hi, 1);
        chk("t4_issues", issue_log.size(), 0);
        chk("t4_acks", aok_cnt[0] + aok_cnt[1] + dok_cnt[0] + dok_cnt[1], 0);

        // 5. stray data_ok in idle
        clear_logs();
        addr_lat = 1; data_lat = 2; rdata_val = 32'h55AA0001;
        @(posedge clk); #3;
        stray = 1;
        repeat (3) @(posedge clk);
        chk("t5_proto_err_set", proto_err, 1'b1);
        chk("t5_no_data_ok", dok_cnt[0] + dok_cnt[1], 0);
        push(1, 1'b0, 32'h00001234, 32'h0, 0);
        wait_done("t5_done", 40);
        chk("t5_data_ok_after", dok_cnt[1], 1);
        chk("t5_rdata_after", dok_rdata[1], 32'h55AA0001);
        chk("t5_proto_err_sticky", proto_err, 1'b1);

        // 6. reset while waiting for data
        clear_logs();
        addr_lat = 1; data_lat = 10;
        push(0, 1'b0, 32'hBFC00004, 32'h0, 0);
        d0 = 0;
        while (!mb_acc && d0 < 20) begin @(posedge clk); d0++; end
        chk("t6_reached_wait", mb_acc, 1'b1);
        @(posedge clk); #3;
        resetn = 0;
        #1;
        chk("t6_br_req", br_if.req, 1'b0);
        chk("t6_m0_acks", {m0_if.addr_ok, m0_if.data_ok}, 2'b00);
        chk("t6_m1_acks", {m1_if.addr_ok, m1_if.data_ok}, 2'b00);
        chk("t6_proto_err", proto_err, 1'b0);
        repeat (2) @(posedge clk); #4;
        resetn = 1;
        clear_logs();
        data_lat = 2; rdata_val = 32'hCAFE0006;
        push(0, 1'b0, 32'hBFC00008, 32'h0, 0);
        wait_done("t6_done", 40);
        chk("t6_data_ok_after", dok_cnt[0], 1);
        chk("t6_rdata_after", dok_rdata[0], 32'hCAFE0006);
        chk("t6_issue_addr", (issue_log.size() > 0) ? issue_log[0] : 32'h0, 32'hBFC00008);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
